// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode/ALUOp constants, control bundle and FSM state codes
// for control_seq and ctrl_decode.
package ctrl_pkg;

  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_ADDI   = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_MOVE   = 3'd5;
  localparam logic [2:0] OP_SHIFT  = 3'd6;
  localparam logic [2:0] OP_EXT    = 3'd7;

  localparam int unsigned ALU_W = 4;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_LSL  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_ASR  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_LSR  = 4'd4;
  localparam logic [ALU_W-1:0] ALU_NOT  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd6;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd7;
  localparam logic [ALU_W-1:0] ALU_MUL  = 4'd8;
  localparam logic [ALU_W-1:0] ALU_PASS = 4'hF;

  typedef struct packed {
    logic             reg_dst;
    logic             branch;
    logic             mem_to_reg;
    logic             mem_write;
    logic             alu_src;
    logic             reg_write;
    logic [ALU_W-1:0] alu_op;
    logic             multicycle;
    logic             illegal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '{
    reg_dst:    1'b0,
    branch:     1'b0,
    mem_to_reg: 1'b0,
    mem_write:  1'b0,
    alu_src:    1'b0,
    reg_write:  1'b0,
    alu_op:     ALU_PASS,
    multicycle: 1'b0,
    illegal:    1'b0
  };

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_TRAP  = 2'd3;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction -> control bundle decoder.
// Illegal encodings return the NOP bundle with the illegal flag set.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned MCODEBITS = 9,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MUL_LAT   = 3
) (
  input  logic [MCODEBITS-1:0] instr,
  output ctrl_bundle_t         bundle
);

  logic [2:0] opcode;
  logic [1:0] funct;

  assign opcode = instr[MCODEBITS-1 -: 3];
  assign funct  = instr[MCODEBITS-4 -: 2];

  // Operand fields below funct do not affect control decode
  generate
    if (MCODEBITS > 5) begin : g_low
      logic unused_low;
      assign unused_low = ^instr[MCODEBITS-6:0];
    end
  endgenerate

  // Opcode/funct table; illegal codes collapse to NOP at the end
  always_comb begin
    logic illegal;
    illegal          = 1'b0;
    bundle           = CTRL_NOP;
    bundle.reg_write = 1'b1;
    bundle.alu_op    = ALU_ADD;
    case (opcode)
      OP_ALU: begin
        case (funct)
          2'b00:   bundle.alu_op = ALU_ADD;
          2'b01:   bundle.alu_op = ALU_SUB;
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        bundle.alu_src    = 1'b1;
        bundle.mem_to_reg = 1'b1;
        bundle.multicycle = (MEM_LAT != 0);
      end
      OP_STORE: begin
        bundle.alu_src   = 1'b1;
        bundle.mem_write = 1'b1;
        bundle.reg_write = 1'b0;
      end
      OP_ADDI: bundle.alu_src = 1'b1;
      OP_BRANCH: begin
        bundle.branch    = 1'b1;
        bundle.reg_write = 1'b0;
        bundle.alu_op    = ALU_SUB;
      end
      OP_MOVE: bundle.alu_op = ALU_PASS;
      OP_SHIFT: begin
        case (funct)
          2'b00:   bundle.alu_op = ALU_LSL;
          2'b01:   bundle.alu_op = ALU_ASR;
          2'b10:   bundle.alu_op = ALU_LSR;
          default: bundle.alu_op = ALU_NOT;
        endcase
      end
      default: begin
        case (funct)
          2'b00: bundle.alu_op = ALU_AND;
          2'b01: bundle.alu_op = ALU_OR;
          2'b10: begin
            bundle.alu_op     = ALU_MUL;
            bundle.multicycle = (MUL_LAT != 0);
          end
          default: illegal = 1'b1;
        endcase
      end
    endcase
    if (illegal) begin
      bundle         = CTRL_NOP;
      bundle.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/control_seq.sv
// control_seq: registered, handshaked control sequencer. Accepts one instr
// per handshake, presents the decoded bundle with ctrl_valid/ctrl_ready and
// holds a busy window for multi-cycle ops (load, mul).
// Optional macro CONTROL_SEQ_ILLEGAL_TRAP_EN adds illegal_trap and a TRAP
// state that parks on an illegal instr until flush.
module control_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned MCODEBITS = 9,
  parameter int unsigned OPWIDTH   = 4,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MUL_LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [MCODEBITS-1:0] instr,
  output logic                 instr_ready,
  input  logic                 flush,
  output logic                 ctrl_valid,
  input  logic                 ctrl_ready,
  output logic                 RegDst,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 busy
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_trap
`endif
);

  localparam int unsigned MAX_LAT = (MEM_LAT > MUL_LAT) ? MEM_LAT : MUL_LAT;
  localparam int unsigned CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MEM_RELOAD = CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
  localparam logic [CW-1:0] MUL_RELOAD = CW'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);

  state_t       state_q, state_d;
  ctrl_bundle_t bundle_q, bundle_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_bundle_t dec;
  logic         accept;
  logic         take_new;

  ctrl_decode #(
    .MCODEBITS (MCODEBITS),
    .MEM_LAT   (MEM_LAT),
    .MUL_LAT   (MUL_LAT)
  ) u_decode (
    .instr  (instr),
    .bundle (dec)
  );

  // Ready: free in IDLE; in ISSUE only when the held single-cycle op drains
  always_comb begin
    case (state_q)
      ST_IDLE:  instr_ready = 1'b1;
      ST_ISSUE: instr_ready = ctrl_ready && !bundle_q.multicycle;
      default:  instr_ready = 1'b0;
    endcase
    if (flush) instr_ready = 1'b0;
  end

  assign accept = instr_valid && instr_ready;

  // Next-state, bundle capture and busy counter; flush overrides everything
  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    cnt_d    = cnt_q;
    take_new = 1'b0;
    case (state_q)
      ST_IDLE: take_new = accept;
      ST_ISSUE: begin
        if (ctrl_ready) begin
          if (bundle_q.multicycle) begin
            state_d = ST_WAIT;
            cnt_d   = (bundle_q.alu_op == ALU_MUL) ? MUL_RELOAD : MEM_RELOAD;
          end else if (accept) begin
            take_new = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
        state_d = ST_TRAP;
`else
        state_d = ST_IDLE;
`endif
      end
    endcase
    if (take_new) begin
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
      if (dec.illegal) begin
        state_d = ST_TRAP;
      end else begin
        bundle_d = dec;
        state_d  = ST_ISSUE;
      end
`else
      bundle_d = dec;
      state_d  = ST_ISSUE;
`endif
    end
    if (flush) state_d = ST_IDLE;
  end

  // State registers with asynchronous active-low reset to IDLE/NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bundle_q <= CTRL_NOP;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      cnt_q    <= cnt_d;
    end
  end

  logic unused_illegal;
  assign unused_illegal = bundle_q.illegal;

  assign ctrl_valid = (state_q == ST_ISSUE);
  assign busy       = (state_q == ST_WAIT);
  assign RegDst     = bundle_q.reg_dst;
  assign Branch     = bundle_q.branch;
  assign MemtoReg   = bundle_q.mem_to_reg;
  assign MemWrite   = bundle_q.mem_write;
  assign ALUSrc     = bundle_q.alu_src;
  assign RegWrite   = bundle_q.reg_write;
  // PASS is all ones at any OPWIDTH; other codes zero-extend
  assign ALUOp      = (bundle_q.alu_op == ALU_PASS) ? '1 : OPWIDTH'(bundle_q.alu_op);

`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
  assign illegal_trap = (state_q == ST_TRAP);
`endif

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed self-checking bench for control_seq
// (MCODEBITS=9, OPWIDTH=4, MEM_LAT=2, MUL_LAT=3).
module tb_control_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic       flush;
  logic       ctrl_valid;
  logic       ctrl_ready;
  logic       RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [3:0] ALUOp;
  logic       busy;
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
  logic       illegal_trap;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_seq #(
    .MCODEBITS (9),
    .OPWIDTH   (4),
    .MEM_LAT   (2),
    .MUL_LAT   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .flush       (flush),
    .ctrl_valid  (ctrl_valid),
    .ctrl_ready  (ctrl_ready),
    .RegDst      (RegDst),
    .Branch      (Branch),
    .MemtoReg    (MemtoReg),
    .MemWrite    (MemWrite),
    .ALUSrc      (ALUSrc),
    .RegWrite    (RegWrite),
    .ALUOp       (ALUOp),
    .busy        (busy)
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
    ,
    .illegal_trap(illegal_trap)
`endif
  );

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] f);
    return {op, f, 4'b0000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Step to #1 after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] flags();
    return {RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp};
  endfunction

  logic [8:0] ops [8];
  logic [9:0] exp_flags [8];

  initial begin
    // {RegDst,Branch,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp}
    ops[0] = mk(3'b011, 2'b00); exp_flags[0] = 10'b000011_0000; // addi
    ops[1] = mk(3'b100, 2'b00); exp_flags[1] = 10'b010000_0001; // branch
    ops[2] = mk(3'b101, 2'b00); exp_flags[2] = 10'b000001_1111; // move
    ops[3] = mk(3'b110, 2'b01); exp_flags[3] = 10'b000001_0011; // ASR
    ops[4] = mk(3'b110, 2'b10); exp_flags[4] = 10'b000001_0100; // LSR
    ops[5] = mk(3'b110, 2'b11); exp_flags[5] = 10'b000001_0101; // NOT
    ops[6] = mk(3'b111, 2'b00); exp_flags[6] = 10'b000001_0110; // and
    ops[7] = mk(3'b111, 2'b01); exp_flags[7] = 10'b000001_0111; // or

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; flush = 1'b0; ctrl_ready = 1'b0;
    #12;
    chk("rst_ctrl_valid", ctrl_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_aluop", ALUOp, 4'hF);
    chk("rst_flags", flags(), 10'b000000_1111);
    rst_n = 1'b1;
    #1;
    chk("rst_instr_ready", instr_ready, 1'b1);

    // Back-to-back add, sub, LSL
    tick();
    ctrl_ready = 1'b1; instr_valid = 1'b1; instr = mk(3'b000, 2'b00);
    #1 chk("s_ready0", instr_ready, 1'b1);
    tick();
    chk("s_valid0", ctrl_valid, 1'b1);
    chk("s_alu0", ALUOp, 4'd0);
    chk("s_rw0", RegWrite, 1'b1);
    instr = mk(3'b000, 2'b01);
    #1 chk("s_ready1", instr_ready, 1'b1);
    tick();
    chk("s_valid1", ctrl_valid, 1'b1);
    chk("s_alu1", ALUOp, 4'd1);
    instr = mk(3'b110, 2'b00);
    #1 chk("s_ready2", instr_ready, 1'b1);
    tick();
    chk("s_valid2", ctrl_valid, 1'b1);
    chk("s_alu2", ALUOp, 4'd2);
    chk("s_rw2", RegWrite, 1'b1);

    // Remaining single-cycle decodes, streamed
    for (int i = 0; i < 8; i++) begin
      instr = ops[i];
      #1 chk("t_ready", instr_ready, 1'b1);
      tick();
      chk("t_valid", ctrl_valid, 1'b1);
      chk($sformatf("t_flags%0d", i), flags(), exp_flags[i]);
    end
    instr_valid = 1'b0;
    tick();
    chk("t_idle", ctrl_valid, 1'b0);

    // Load: 1 valid cycle, 2 busy cycles, ready low for 3
    instr_valid = 1'b1; instr = mk(3'b001, 2'b00);
    tick();
    instr_valid = 1'b0;
    #1;
    chk("ld_valid", ctrl_valid, 1'b1);
    chk("ld_flags", flags(), 10'b001011_0000);
    chk("ld_ready0", instr_ready, 1'b0);
    chk("ld_busy0", busy, 1'b0);
    tick();
    chk("ld_valid1", ctrl_valid, 1'b0);
    chk("ld_busy1", busy, 1'b1);
    chk("ld_ready1", instr_ready, 1'b0);
    chk("ld_hold1", MemtoReg, 1'b1);
    tick();
    chk("ld_busy2", busy, 1'b1);
    chk("ld_ready2", instr_ready, 1'b0);
    tick();
    chk("ld_busy3", busy, 1'b0);
    chk("ld_ready3", instr_ready, 1'b1);

    // Store held under backpressure for 4 cycles
    ctrl_ready = 1'b0; instr_valid = 1'b1; instr = mk(3'b010, 2'b00);
    tick();
    instr = mk(3'b000, 2'b01);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_valid", ctrl_valid, 1'b1);
      chk("st_flags", flags(), 10'b000110_0000);
      chk("st_ready", instr_ready, 1'b0);
      tick();
    end
    ctrl_ready = 1'b1; instr_valid = 1'b0;
    #1 chk("st_release_ready", instr_ready, 1'b1);
    tick();
    chk("st_done", ctrl_valid, 1'b0);
    chk("st_no_accept", MemWrite, 1'b1);

    // Mul, flush in 2nd WAIT cycle with a pending instr
    instr_valid = 1'b1; instr = mk(3'b111, 2'b10);
    tick();
    instr_valid = 1'b0;
    #1;
    chk("mul_valid", ctrl_valid, 1'b1);
    chk("mul_alu", ALUOp, 4'd8);
    chk("mul_ready", instr_ready, 1'b0);
    tick();
    chk("mul_wait1", busy, 1'b1);
    tick();
    chk("mul_wait2", busy, 1'b1);
    flush = 1'b1; instr_valid = 1'b1; instr = mk(3'b000, 2'b00);
    #1 chk("fl_ready", instr_ready, 1'b0);
    tick();
    chk("fl_busy", busy, 1'b0);
    chk("fl_valid", ctrl_valid, 1'b0);
    flush = 1'b0; instr_valid = 1'b0;
    #1 chk("fl_idle_ready", instr_ready, 1'b1);
    tick();
    chk("fl_not_accepted", ctrl_valid, 1'b0);
    chk("fl_alu_kept", ALUOp, 4'd8);

    // Reset mid-WAIT after mul
    instr_valid = 1'b1; instr = mk(3'b111, 2'b10);
    tick();
    instr_valid = 1'b0;
    tick();
    chk("rw_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rw_valid", ctrl_valid, 1'b0);
    chk("rw_busy0", busy, 1'b0);
    chk("rw_alu", ALUOp, 4'hF);
    tick();
    rst_n = 1'b1;
    #1 chk("rw_ready", instr_ready, 1'b1);

    // Illegal instruction 111_11
    tick();
    instr_valid = 1'b1; instr = mk(3'b111, 2'b11);
    tick();
    instr_valid = 1'b0;
    #1;
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
    chk("il_valid", ctrl_valid, 1'b0);
    chk("il_trap", illegal_trap, 1'b1);
    chk("il_ready", instr_ready, 1'b0);
    tick();
    tick();
    chk("il_trap_hold", illegal_trap, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("il_trap_clr", illegal_trap, 1'b0);
    chk("il_ready_after", instr_ready, 1'b1);
`else
    chk("il_valid", ctrl_valid, 1'b1);
    chk("il_flags", flags(), 10'b000000_1111);
    tick();
    chk("il_done", ctrl_valid, 1'b0);
    // 000_1x is also illegal
    instr_valid = 1'b1; instr = mk(3'b000, 2'b10);
    tick();
    instr_valid = 1'b0;
    #1;
    chk("il2_valid", ctrl_valid, 1'b1);
    chk("il2_flags", flags(), 10'b000000_1111);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
